range_mult_pipe: RTL and testbench

// - 2-stage pipelined range-split multiplier for the AV1 arithmetic encoder range update.
// - Computes u = ((range >> 8) * (cdf >> 6)) >> 1 + 4 * (nsyms - symbol).
// - Sits between the CDF/symbol fetch stage and the low/range renormalisation stage.
// - The 8x10 product is built from the vedic_2x2 multiplier tree (vedic_8x10 composition).
// - Valid/ready handshake on both sides; full backpressure support.

---
 rtl/range_mult_pipe.sv | 161 ++++++++++++++++
 tb/tb_range_mult_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_mult_pipe.sv
`default_nettype none
// =============================================================================
// range_mult_pipe : 2-stage AV1 range-split multiplier, valid/ready both sides.
// Optional build macro RANGE_MULT_PIPE_STATS_EN adds stat_ops/stat_stalls.
// Revision: 1.0 - initial release
// =============================================================================

module vedic_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic w_m10, w_m01, w_m11, w_c1;

    assign w_m10  = a_i[1] & b_i[0];
    assign w_m01  = a_i[0] & b_i[1];
    assign w_m11  = a_i[1] & b_i[1];
    assign w_c1   = w_m10 & w_m01;
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = w_m10 ^ w_m01;
    assign p_o[2] = w_m11 ^ w_c1;
    assign p_o[3] = w_m11 & w_c1;
endmodule

module range_mult_pipe #(
    parameter int RANGE_WIDTH = 16,
    parameter int SYM_WIDTH   = 5,
    parameter int OUT_WIDTH   = RANGE_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANGE_WIDTH-1:0] in_range,
    input  logic [RANGE_WIDTH-1:0] in_cdf,
    input  logic [SYM_WIDTH-1:0]   in_nsyms,
    input  logic [SYM_WIDTH-1:0]   in_symbol,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_u,
    output logic                   out_err
`ifdef RANGE_MULT_PIPE_STATS_EN
    ,
    output logic [31:0]            stat_ops,
    output logic [31:0]            stat_stalls
`endif
);
    localparam int A_W    = 8;
    localparam int B_W    = 10;
    localparam int A_LSB  = RANGE_WIDTH - A_W;
    localparam int B_LSB  = RANGE_WIDTH - B_W;
    localparam int A_DIG  = A_W / 2;
    localparam int B_DIG  = B_W / 2;
    localparam int PROD_W = A_W + B_W;
    localparam int T_W    = SYM_WIDTH + 2;

    logic                 s1_valid_q, out_valid_q;
    logic [A_W-1:0]       a_q, a_d;
    logic [B_W-1:0]       b_q, b_d;
    logic [T_W-1:0]       t_q, t_d;
    logic                 s1_err_q, err_d;
    logic [OUT_WIDTH-1:0] out_u_q, u_d;
    logic                 out_err_q;
    logic                 s2_ready;
    logic [PROD_W-1:0]    prod;
    logic [3:0]           pp [A_DIG*B_DIG];
    logic                 w_unused;

    assign w_unused = ^{in_range[A_LSB-1:0], in_cdf[B_LSB-1:0]};

    // Output stage can take new data when empty or when its result leaves.
    assign s2_ready = !out_valid_q | out_ready;
    assign in_ready = !s1_valid_q | s2_ready;

    assign a_d   = in_range[RANGE_WIDTH-1:A_LSB];
    assign b_d   = in_cdf[RANGE_WIDTH-1:B_LSB];
    assign err_d = in_symbol > in_nsyms;
    assign t_d   = err_d ? '0 : {in_nsyms - in_symbol, 2'b00};

    generate
        for (genvar i = 0; i < A_DIG; i++) begin : g_row
            for (genvar j = 0; j < B_DIG; j++) begin : g_col
                vedic_2x2 u_pp (
                    .a_i (a_q[2*i +: 2]),
                    .b_i (b_q[2*j +: 2]),
                    .p_o (pp[i*B_DIG + j])
                );
            end
        end
    endgenerate

    // Each 2x2 digit product lands at bit 2*(i+j) of the full product.
    always_comb begin
        prod = '0;
        for (int i = 0; i < A_DIG; i++) begin
            for (int j = 0; j < B_DIG; j++) begin
                prod = prod + (PROD_W'(pp[i*B_DIG + j]) << (2 * (i + j)));
            end
        end
    end

    assign u_d = OUT_WIDTH'(prod >> 1) + OUT_WIDTH'(t_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            t_q         <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_u_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    t_q      <= t_d;
                    s1_err_q <= err_d;
                end
            end
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_u_q   <= u_d;
                    out_err_q <= s1_err_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_u     = out_u_q;
    assign out_err   = out_err_q;

`ifdef RANGE_MULT_PIPE_STATS_EN
    logic [31:0] stat_ops_q, stat_stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ops_q    <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (out_valid_q && !out_ready) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_ops    = stat_ops_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_range_mult_pipe.sv
`default_nettype none
// =============================================================================
// tb_range_mult_pipe : vector table, corner sequences and random stream with a
// queue-based reference for range_mult_pipe.  Revision: 1.0
// =============================================================================
module tb_range_mult_pipe;
    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        logic [4:0]  n;
        logic [4:0]  s;
        logic [16:0] u;
        logic        e;
    } vec_t;

    typedef struct {
        logic [16:0] u;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_range, in_cdf;
    logic [4:0]  in_nsyms, in_symbol;
    logic        out_valid, out_ready, out_err;
    logic [16:0] out_u;
    logic        rand_bp = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        force_ready = 1'b1;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic        prev_stall = 1'b0;
    logic [16:0] prev_u;
    logic        prev_e;
`ifdef RANGE_MULT_PIPE_STATS_EN
    logic [31:0] stat_ops, stat_stalls;
    int          m_ops = 0;
    int          m_stalls = 0;
`endif

    assign out_ready = rand_bp ? rnd_ready : force_ready;

    range_mult_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_range  (in_range),
        .in_cdf    (in_cdf),
        .in_nsyms  (in_nsyms),
        .in_symbol (in_symbol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u     (out_u),
        .out_err   (out_err)
`ifdef RANGE_MULT_PIPE_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic exp_t model(int r, int c, int n, int s);
        exp_t x;
        int   t;
        t   = (s <= n) ? 4 * (n - s) : 0;
        x.u = 17'(((r / 256) * (c / 64)) / 2 + t);
        x.e = (s > n);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Output monitor: every transfer is compared in order against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid: got %b expected 0", out_valid);
            end
            prev_stall = 1'b0;
`ifdef RANGE_MULT_PIPE_STATS_EN
            m_ops = 0;
            m_stalls = 0;
`endif
        end else begin
            if (prev_stall && out_valid) begin
                checks++;
                if (out_u !== prev_u || out_err !== prev_e) begin
                    errors++;
                    $display("FAIL stall_hold: got u=%0d e=%b expected u=%0d e=%b", out_u, out_err, prev_u, prev_e);
                end
            end
            if (out_valid && out_ready) begin
                exp_t x;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output: got u=%0d expected no output", out_u);
                end else begin
                    x = exp_q.pop_front();
                    if (out_u !== x.u || out_err !== x.e) begin
                        errors++;
                        $display("FAIL result: got u=%0d err=%b expected u=%0d err=%b", out_u, out_err, x.u, x.e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_u     = out_u;
            prev_e     = out_err;
`ifdef RANGE_MULT_PIPE_STATS_EN
            if (out_valid && out_ready) m_ops++;
            if (out_valid && !out_ready) m_stalls++;
`endif
        end
    end

    task automatic send(input logic [15:0] r, input logic [15:0] c, input logic [4:0] n,
                        input logic [4:0] s, input logic [16:0] eu, input logic ee);
        bit got = 0;
        int w = 0;
        exp_t x;
        in_valid = 1'b1; in_range = r; in_cdf = c; in_nsyms = n; in_symbol = s;
        while (!got && w < 100) begin
            @(negedge clk);
            if (in_ready) got = 1;
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b0;
        if (got) begin
            x.u = eu; x.e = ee;
            exp_q.push_back(x);
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic send_model(input logic [15:0] r, input logic [15:0] c,
                              input logic [4:0] n, input logic [4:0] s);
        exp_t x;
        x = model(int'(r), int'(c), int'(n), int'(s));
        send(r, c, n, s, x.u, x.e);
    endtask

    task automatic drain();
        int w = 0;
        rand_bp = 1'b0; force_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 60) begin
            @(posedge clk); #1; w++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    vec_t tbl[7];

    initial begin
        int lat;
        int acc;
        bit will;
        vec_t bp[3];

        tbl[0] = '{16'h8000, 16'h4000, 5'd4,  5'd1,  17'd16396,  1'b0};
        tbl[1] = '{16'hFFFF, 16'h7FFF, 5'd16, 5'd0,  17'd65216,  1'b0};
        tbl[2] = '{16'hFFFF, 16'h003F, 5'd3,  5'd3,  17'd0,      1'b0};
        tbl[3] = '{16'h8000, 16'h4000, 5'd4,  5'd5,  17'h04000,  1'b1};
        tbl[4] = '{16'h00FF, 16'h7FFF, 5'd10, 5'd2,  17'd32,     1'b0};
        tbl[5] = '{16'hC000, 16'h2000, 5'd7,  5'd7,  17'd12288,  1'b0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 5'd31, 5'd0,  17'd130556, 1'b0};

        reset = 1'b0; in_valid = 1'b0;
        in_range = '0; in_cdf = '0; in_nsyms = '0; in_symbol = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_u", int'(out_u), 0);
        chk("reset_out_err", int'(out_err), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // Latency of the first transaction with no stall.
        send(tbl[0].r, tbl[0].c, tbl[0].n, tbl[0].s, tbl[0].u, tbl[0].e);
        lat = 0;
        while (!out_valid && lat < 3) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!out_valid || lat > 1) begin
            errors++;
            $display("FAIL latency: got %0d extra edges expected at most 1", lat);
        end
        drain();

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].r, tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].u, tbl[i].e);
        end
        drain();

        // Backpressure: three offers while out_ready is held low for five cycles.
        bp[0] = '{16'h1234, 16'h5678, 5'd9,  5'd3,  17'd0, 1'b0};
        bp[1] = '{16'hABCD, 16'h7000, 5'd20, 5'd20, 17'd0, 1'b0};
        bp[2] = '{16'h7FFF, 16'h0FFF, 5'd1,  5'd4,  17'd0, 1'b0};
        force_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (acc < 3);
            in_range = bp[acc % 3].r; in_cdf = bp[acc % 3].c;
            in_nsyms = bp[acc % 3].n; in_symbol = bp[acc % 3].s;
            @(negedge clk);
            will = in_valid && in_ready;
            @(posedge clk); #1;
            if (will) begin
                exp_q.push_back(model(int'(bp[acc].r), int'(bp[acc].c), int'(bp[acc].n), int'(bp[acc].s)));
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        force_ready = 1'b1;
        send_model(bp[2].r, bp[2].c, bp[2].n, bp[2].s);
        drain();
`ifdef RANGE_MULT_PIPE_STATS_EN
        chk("stat_ops", int'(stat_ops), m_ops);
        chk("stat_stalls", int'(stat_stalls), m_stalls);
`endif

        // Reset with two transactions in flight.
        force_ready = 1'b0;
        send_model(16'h9000, 16'h6000, 5'd8, 5'd2);
        send_model(16'h4000, 16'h3000, 5'd2, 5'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_reset_out_valid", int'(out_valid), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        force_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_stale_output", int'(out_valid), 0);
        end
        send_model(16'h8000, 16'h4000, 5'd4, 5'd1);
        drain();

        // Random stream with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] r, c;
            r = 16'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            send_model(r, c, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        drain();
`ifdef RANGE_MULT_PIPE_STATS_EN
        chk("stat_ops_random", int'(stat_ops), m_ops);
        chk("stat_stalls_random", int'(stat_stalls), m_stalls);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
